mix_columns_engine: RTL and testbench
=====================================

Name: mix_columns_engine

Overview:
- Sequential, parametrised successor to the combinational AES MixColumns stage.
- Accepts a 128-bit AES state over a valid/ready handshake and runs forward MixColumns, or InvMixColumns when compiled in.
- Processes COLS_PER_CYCLE columns per clock, so area is traded against latency.
- Sits between ShiftRows and AddRoundKey in the iterative round datapath. Used in the decrypt path when inverse mode is enabled.

Parameters:
- COLS_PER_CYCLE, 4, columns transformed per clock. Legal values are 1, 2, 4; any other value is an elaboration error.
- ITER, 4/COLS_PER_CYCLE, derived localparam: number of compute cycles per state. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_inv are valid.
- in_ready  output  1  engine can accept a state.
- in_data  input  128  AES state, column-major: column c = [127-32c -: 32], row 0 in the MSB byte.
- in_inv  input  1  1 = InvMixColumns, 0 = MixColumns. Sampled at acceptance.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  transformed state, same byte layout as in_data.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - in_ready=0 while rst_n is low; in_ready=1 from the first clock after release.
  - out_valid=0, busy=0, out_data=0, internal data, column index and mode registers cleared.
  - Reset mid-operation discards the state in flight; no partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the working register, latch in_inv, clear col_idx, go to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each cycle, transform columns col_idx*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 in place; untouched columns hold.
  - col_idx increments each cycle.
  - On the cycle the last group is processed, go to DONE.
- DONE:
  - out_valid=1, out_data=working register, in_ready=0.
  - out_data and out_valid are held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE.
  - A new input is never accepted in the same cycle as the output handshake; the earliest acceptance is the following cycle.
  - Throughput is one state per ITER+2 cycles.
- Latency: out_valid rises ITER clock edges after the accepting edge (1 for COLS_PER_CYCLE=4, 4 for COLS_PER_CYCLE=1).
- Column arithmetic over GF(2^8), polynomial 0x11B, with xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - Forward, for column bytes a0..a3:
    - r0 = 2a0^3a1^a2^a3
    - r1 = a0^2a1^3a2^a3
    - r2 = a0^a1^2a2^3a3
    - r3 = 3a0^a1^a2^2a3
  - Inverse uses coefficients {0E,0B,0D,09} in the same rotation, r0 = 0E·a0^0B·a1^0D·a2^09·a3, built from repeated xtime.
  - Pure XOR logic: no carries, all intermediate values 8 bits.
- col_idx width is max(1,$clog2(ITER)). It wraps to 0 on the transition to DONE.
- Outputs are driven directly from registers; no combinational path from in_* to out_*. in_ready depends only on the FSM state.

Optional Feature:
- Macro: MIXCOL_INV_EN.
- Defined: in_inv selects InvMixColumns as described above.
- Undefined:
  - No inverse multipliers are synthesised.
  - in_inv is ignored and the mode register is not instantiated.
  - All states receive forward MixColumns.
  - The port list is unchanged.

Test Plan:
- Forward, COLS_PER_CYCLE=4, in_inv=0:
  - in_data=db135345_f20a225c_01010101_c6c6c6c6 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - out_valid rises 1 cycle after acceptance.
- COLS_PER_CYCLE=1, same vector:
  - identical out_data; out_valid 4 cycles after acceptance; in_ready=0 throughout BUSY/DONE.
  - in_valid pulsed during BUSY is ignored.
- Backpressure:
  - out_ready held 0 for 10 cycles -> out_data/out_valid stable.
  - out_ready=1 -> next cycle in_ready=1, busy=0.
  - A back-to-back second vector d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> 046681e5_e0cb199a_48f8d37a_2806264c.
- Inverse (MIXCOL_INV_EN defined), in_inv=1:
  - in_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_data=db135345_f20a225c_01010101_c6c6c6c6.
  - The same vector with the macro undefined yields the forward result.
- Reset mid-operation, COLS_PER_CYCLE=1:
  - Drop rst_n in the 2nd BUSY cycle -> out_valid=0, out_data=0 immediately (asynchronous); in_ready=0 while rst_n is low.
  - in_ready=1 on the first clock after release; the next vector processes correctly.
- Identity and all-zero inputs, all three COLS_PER_CYCLE values:
  - in_data=01010101 x4 -> unchanged.
  - in_data=0 -> 0.

Source files
------------

// File: rtl/mix_columns_engine_if.sv
// Handshake bundle for mix_columns_engine: state input channel, result channel and busy flag.
interface mix_columns_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns engine transforming COLS_PER_CYCLE columns per clock.
// Define MIXCOL_INV_EN to build the InvMixColumns path selected by in_inv.

module mix_col_lane (
  input  logic [31:0] col,
`ifdef MIXCOL_INV_EN
  input  logic        inv,
`endif
  output logic [31:0] res
);
  // Byte-parallel xtime: each byte shifted left, 0x1B folded in where its MSB was set.
  function automatic logic [31:0] xt4(input logic [31:0] w);
    logic [31:0] l;
    l = (w >> 7) & 32'h0101_0101;
    return ((w << 1) & 32'hFEFE_FEFE) ^ (l << 4) ^ (l << 3) ^ (l << 1) ^ l;
  endfunction

  // Rotate so byte i of the result is byte i+n of the input (row 0 in the MSB).
  function automatic logic [31:0] rl1(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [31:0] rl2(input logic [31:0] w);
    return {w[15:0], w[31:16]};
  endfunction
  function automatic logic [31:0] rl3(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  logic [31:0] m2, m3, fwd;

  assign m2  = xt4(col);
  assign m3  = m2 ^ col;
  assign fwd = m2 ^ rl1(m3) ^ rl2(col) ^ rl3(col);

`ifdef MIXCOL_INV_EN
  logic [31:0] m4, m8, m9, mb, md, me, rev;

  assign m4  = xt4(m2);
  assign m8  = xt4(m4);
  assign m9  = m8 ^ col;
  assign mb  = m8 ^ m2 ^ col;
  assign md  = m8 ^ m4 ^ col;
  assign me  = m8 ^ m4 ^ m2;
  assign rev = me ^ rl1(mb) ^ rl2(md) ^ rl3(m9);
  assign res = inv ? rev : fwd;
`else
  assign res = fwd;
`endif
endmodule

module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mix_columns_engine_if.slave  bus
);
  localparam int ITER = 4 / COLS_PER_CYCLE;
  localparam int CIW  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CIW-1:0] LAST = CIW'(ITER - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                          state_q, state_d;
  logic [CIW-1:0]                  col_idx_q, col_idx_d;
  logic [3:0][31:0]                work_q, work_d, work_nx;
  logic [127:0]                    out_data_q, out_data_d;
  logic                            out_valid_q, out_valid_d;
  logic                            in_ready_q, in_ready_d;
  logic                            busy_q, busy_d;
  logic [COLS_PER_CYCLE-1:0][31:0] lane_in, lane_out;

`ifdef MIXCOL_INV_EN
  logic mode_q, mode_d;
`else
  logic unused_in_inv;
  assign unused_in_inv = bus.in_inv;
`endif

  // work_q[3] is column 0 (bits 127:96); lane k serves column col_idx*COLS_PER_CYCLE+k.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    logic [1:0] pos;
    assign pos         = 2'(3 - k - int'(col_idx_q) * COLS_PER_CYCLE);
    assign lane_in[k]  = work_q[pos];

    mix_col_lane u_lane (
      .col (lane_in[k]),
`ifdef MIXCOL_INV_EN
      .inv (mode_q),
`endif
      .res (lane_out[k])
    );
  end

  for (genvar c = 0; c < 4; c++) begin : g_wb
    assign work_nx[3-c] = (col_idx_q == CIW'(c / COLS_PER_CYCLE)) ?
                          lane_out[c % COLS_PER_CYCLE] : work_q[3-c];
  end

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    work_d      = work_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
`ifdef MIXCOL_INV_EN
    mode_d      = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          work_d     = bus.in_data;
          col_idx_d  = '0;
          state_d    = BUSY;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef MIXCOL_INV_EN
          mode_d     = bus.in_inv;
`endif
        end
      end
      BUSY: begin
        work_d    = work_nx;
        col_idx_d = col_idx_q + 1'b1;
        if (col_idx_q == LAST) begin
          col_idx_d   = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = work_nx;
        end
      end
      DONE: begin
        // Return to IDLE with in_ready already set so the next state is taken one cycle later.
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_idx_q   <= '0;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MIXCOL_INV_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef MIXCOL_INV_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (1, 2, 4 columns per cycle) against a GF(2^8) matrix model.
module tb_mix_columns_engine;
`ifdef MIXCOL_INV_EN
  localparam bit INV_BUILT = 1'b1;
`else
  localparam bit INV_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int nvec = 0;
  int nerr = 0;

  mix_columns_engine_if if_c1 ();
  mix_columns_engine_if if_c2 ();
  mix_columns_engine_if if_c4 ();

  // Index d: 0 -> 1 column/cycle, 1 -> 2, 2 -> 4.
  logic [2:0]   iv, vinv, orr;
  logic [127:0] din [3];
  wire  [2:0]   ir, ov, bz;
  wire  [127:0] od [3];

  assign if_c1.in_valid = iv[0];  assign if_c1.in_data = din[0];
  assign if_c1.in_inv   = vinv[0]; assign if_c1.out_ready = orr[0];
  assign ir[0] = if_c1.in_ready;  assign ov[0] = if_c1.out_valid;
  assign bz[0] = if_c1.busy;      assign od[0] = if_c1.out_data;

  assign if_c2.in_valid = iv[1];  assign if_c2.in_data = din[1];
  assign if_c2.in_inv   = vinv[1]; assign if_c2.out_ready = orr[1];
  assign ir[1] = if_c2.in_ready;  assign ov[1] = if_c2.out_valid;
  assign bz[1] = if_c2.busy;      assign od[1] = if_c2.out_data;

  assign if_c4.in_valid = iv[2];  assign if_c4.in_data = din[2];
  assign if_c4.in_inv   = vinv[2]; assign if_c4.out_ready = orr[2];
  assign ir[2] = if_c4.in_ready;  assign ov[2] = if_c4.out_valid;
  assign bz[2] = if_c4.busy;      assign od[2] = if_c4.out_data;

  mix_columns_engine #(.COLS_PER_CYCLE(1)) u_c1 (.clk(clk), .rst_n(rst_n), .bus(if_c1));
  mix_columns_engine #(.COLS_PER_CYCLE(2)) u_c2 (.clk(clk), .rst_n(rst_n), .bus(if_c2));
  mix_columns_engine #(.COLS_PER_CYCLE(4)) u_c4 (.clk(clk), .rst_n(rst_n), .bus(if_c4));

  // Reference: generic GF(2^8) multiply and the circulant coefficient matrix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [31:0]  cf, col;
    logic [7:0]   r;
    logic [127:0] o;
    o  = '0;
    cf = (inv && INV_BUILT) ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++)
          r ^= gmul(cf[31-8*((j-i+4)%4) -: 8], col[31-8*j -: 8]);
        o[127-32*c-8*i -: 8] = r;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input int d, input logic [127:0] data, input bit inv);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir[d] && n < 50) begin @(negedge clk); n++; end
    if (!ir[d]) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b, required 1", d, ir[d]);
    end
    din[d] = data; vinv[d] = inv; iv[d] = 1'b1;
    @(posedge clk); #1 iv[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!ov[d] && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!ov[d]) begin
      nvec++; nerr++;
      $display("FAIL out_timeout dut%0d: out_valid=%b, required 1", d, ov[d]);
    end
  endtask

  task automatic take(input int d);
    orr[d] = 1'b1;
    @(posedge clk); #1 orr[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iv = '0; vinv = '0; orr = '0;
    for (int d = 0; d < 3; d++) din[d] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      nvec++;
      if (ir[d] !== 1'b0 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || od[d] !== 128'h0) begin
        nerr++;
        $display("FAIL reset_state dut%0d: ir=%b ov=%b busy=%b out=%h, required 0 0 0 0", d, ir[d], ov[d], bz[d], od[d]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      nvec++;
      if (ir[d] !== 1'b1) begin
        nerr++;
        $display("FAIL ready_after_reset dut%0d: in_ready=%b, required 1", d, ir[d]);
      end
    end
  endtask

  task automatic test_forward();
    logic [127:0] v, e;
    int lat;
    send(2, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    wait_out(2, lat);
    nvec++;
    if (od[2] !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 || lat != 1) begin
      nerr++;
      $display("FAIL fwd_known: out=%h lat=%0d, required 8e4da1bc9fdc589d01010101c6c6c6c6 lat=1", od[2], lat);
    end
    take(2);
    for (int d = 0; d < 3; d++)
      for (int t = 0; t < 6; t++) begin
        v = rnd128(); e = ref_mix(v, 1'b0);
        send(d, v, 1'b0);
        wait_out(d, lat);
        nvec++;
        if (od[d] !== e || lat != (4 >> d)) begin
          nerr++;
          $display("FAIL fwd_rand dut%0d: in=%h out=%h lat=%0d, required %h lat=%0d", d, v, od[d], lat, e, 4 >> d);
        end
        take(d);
      end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] v;
    int n;
    v = rnd128();
    send(0, v, 1'b0);
    n = 0;
    while (!ov[0] && n < 10) begin
      nvec++;
      if (ir[0] !== 1'b0 || bz[0] !== 1'b1) begin
        nerr++;
        $display("FAIL busy_flags cyc%0d: ir=%b busy=%b, required 0 1", n, ir[0], bz[0]);
      end
      if (n == 1) begin iv[0] = 1'b1; din[0] = ~v; end
      @(posedge clk); #1; n++;
    end
    nvec++;
    if (ir[0] !== 1'b0 || bz[0] !== 1'b1 || od[0] !== ref_mix(v, 1'b0) || n != 4) begin
      nerr++;
      $display("FAIL busy_ignore: ir=%b busy=%b out=%h lat=%0d, required 0 1 %h 4", ir[0], bz[0], od[0], n, ref_mix(v, 1'b0));
    end
    iv[0] = 1'b0;
    take(0);
  endtask

  task automatic test_backpressure();
    logic [127:0] v, e;
    int lat;
    v = rnd128(); e = ref_mix(v, 1'b0);
    send(2, v, 1'b0);
    wait_out(2, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      nvec++;
      if (ov[2] !== 1'b1 || od[2] !== e) begin
        nerr++;
        $display("FAIL hold cyc%0d: ov=%b out=%h, required 1 %h", i, ov[2], od[2], e);
      end
    end
    take(2);
    nvec++;
    if (ir[2] !== 1'b1 || bz[2] !== 1'b0 || ov[2] !== 1'b0) begin
      nerr++;
      $display("FAIL release: ir=%b busy=%b ov=%b, required 1 0 0", ir[2], bz[2], ov[2]);
    end
    send(2, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0);
    wait_out(2, lat);
    nvec++;
    if (od[2] !== 128'h046681e5_e0cb199a_48f8d37a_2806264c || lat != 1) begin
      nerr++;
      $display("FAIL back_to_back: out=%h lat=%0d, required 046681e5e0cb199a48f8d37a2806264c lat=1", od[2], lat);
    end
    take(2);
  endtask

  task automatic test_inverse();
    logic [127:0] v, e;
    int lat;
    v = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    e = INV_BUILT ? 128'hdb135345_f20a225c_01010101_c6c6c6c6 : ref_mix(v, 1'b0);
    send(2, v, 1'b1);
    wait_out(2, lat);
    nvec++;
    if (od[2] !== e) begin
      nerr++;
      $display("FAIL inv_known: out=%h, required %h", od[2], e);
    end
    take(2);
    for (int d = 0; d < 3; d++)
      for (int t = 0; t < 4; t++) begin
        v = rnd128(); e = ref_mix(v, 1'b1);
        send(d, v, 1'b1);
        wait_out(d, lat);
        nvec++;
        if (od[d] !== e) begin
          nerr++;
          $display("FAIL inv_rand dut%0d: in=%h out=%h, required %h", d, v, od[d], e);
        end
        take(d);
      end
  endtask

  task automatic test_reset_mid();
    logic [127:0] v;
    int lat;
    send(0, rnd128(), 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (ov[0] !== 1'b0 || od[0] !== 128'h0 || ir[0] !== 1'b0 || bz[0] !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset: ov=%b out=%h ir=%b busy=%b, required 0 0 0 0", ov[0], od[0], ir[0], bz[0]);
    end
    repeat (2) begin
      @(posedge clk); #1;
      nvec++;
      if (ir[0] !== 1'b0) begin
        nerr++;
        $display("FAIL ready_in_reset: in_ready=%b, required 0", ir[0]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
      nerr++;
      $display("FAIL ready_after_mid_reset: ir=%b ov=%b, required 1 0", ir[0], ov[0]);
    end
    v = rnd128();
    send(0, v, 1'b0);
    wait_out(0, lat);
    nvec++;
    if (od[0] !== ref_mix(v, 1'b0) || lat != 4) begin
      nerr++;
      $display("FAIL post_reset_vec: out=%h lat=%0d, required %h lat=4", od[0], lat, ref_mix(v, 1'b0));
    end
    take(0);
  endtask

  task automatic test_identity_zero();
    logic [127:0] v;
    int lat;
    for (int d = 0; d < 3; d++)
      for (int t = 0; t < 2; t++) begin
        v = (t == 0) ? {4{32'h01010101}} : 128'h0;
        send(d, v, 1'b0);
        wait_out(d, lat);
        nvec++;
        if (od[d] !== v) begin
          nerr++;
          $display("FAIL fixed_point dut%0d: in=%h out=%h, required %h", d, v, od[d], v);
        end
        take(d);
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_busy_ignore();
    test_backpressure();
    test_inverse();
    test_reset_mid();
    test_identity_zero();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
